handshake_pipe_fifo: RTL and testbench
======================================

Name: handshake_pipe_fifo

Overview:
- Clocked, parametrised successor to the two-phase (transition-signalled) req/ack bundled-data stage.
- Accepts words from an upstream two-phase channel and buffers them in a DEPTH-entry FIFO.
- Re-issues the words on a downstream two-phase channel, decoupling the two sides.
- Both incoming handshake toggles are synchronised, so the channels may be driven from unrelated timing domains.
- Adds occupancy reporting and sticky protocol-violation detection.

Parameters:
- DATA_WIDTH, 3: payload width in bits.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2: flops in each of the req_in and ack_in synchronisers; at least 1.

Ports:
- clk  in  1  single clock; all state is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_in  in  1  upstream request; each toggle offers one word.
- ack_out  out  1  upstream acknowledge; a toggle means the word has been captured.
- data_in  in  DATA_WIDTH  upstream payload; stable from the req_in toggle until the ack_out toggle.
- req_out  out  1  downstream request; a toggle means data_out is valid.
- ack_in  in  1  downstream acknowledge; a toggle releases data_out.
- data_out  out  DATA_WIDTH  downstream payload register.
- count  out  $clog2(DEPTH+1)  FIFO occupancy, excluding the output register.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (asynchronous, rst_n=0): ack_out=0, req_out=0, data_out=0, count=0, proto_err=0, all synchroniser flops=0, FIFO pointers=0.
- Reset mid-transfer discards all buffered and in-flight words. Both channels restart at phase 0, and the environment must also return req_in and ack_in to 0.
- Synchronisers: req_s and ack_s are req_in and ack_in delayed through SYNC_STAGES flops.
- Input side:
  - in_pend = (req_s != ack_out).
  - On an edge with in_pend=1 and count<DEPTH: write data_in at wr_ptr, advance wr_ptr, toggle ack_out.
  - Latency: a req_in toggle before edge 0 toggles ack_out at edge SYNC_STAGES (edge 2 for the default).
  - Full (count==DEPTH): the push stalls and ack_out holds. A pop on the same edge does not unblock the push; the push takes place on the following edge.
- Output side:
  - out_busy = (req_out != ack_s).
  - On an edge with out_busy=0 and count>0: load data_out from rd_ptr, advance rd_ptr, toggle req_out.
  - data_out changes only on that edge.
  - There is no empty bypass: a word written at edge n appears on data_out with the req_out toggle at edge n+1 at the earliest.
- Simultaneous events:
  - Push and pop on the same edge leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - Total in-flight capacity is DEPTH+1 words (FIFO plus output register).
- proto_err is set, and held until reset, on either violation:
  - ack_s changes while out_busy=0, i.e. an acknowledge with no outstanding request.
  - req_s changes while in_pend=1, i.e. a second request before the acknowledge.
- Violations do not corrupt the pointers.
- A violating ack is ignored: out_busy simply re-evaluates from the signals.
- A double-toggled req cancels in_pend and no word is taken.

Decomposition:
- A shared package holds:
  - the phase-0 reset constant;
  - the occupancy-width function $clog2(DEPTH+1);
  - a DATA_WIDTH payload typedef for reuse by sibling pipeline blocks.
- Sub-module hs_sync: a SYNC_STAGES-deep single-bit synchroniser with asynchronous active-low clear, instantiated once for req_in and once for ack_in.
- FIFO storage and pointers stay inline.

Test Plan:
- Single word: reset, then toggle req_in 0→1 with data_in=1 and hold ack_in=0.
  - ack_out toggles to 1 at edge 2 and count=1.
  - req_out toggles to 1 at edge 3 with data_out=1 and count=0.
- Stream order: send 1, 2, 3, 4 as alternating req_in phases, with the downstream side acknowledging each req_out toggle 3 cycles later.
  - data_out sequence is 1, 2, 3, 4.
  - ack_out and req_out each toggle 4 times.
  - proto_err stays 0.
- Full/backpressure: DEPTH=4, ack_in frozen, send 6 words.
  - 5 acks are issued: 4 in the FIFO plus 1 in data_out.
  - count=4 and the 6th ack_out toggle is withheld.
  - One ack_in toggle releases data_out=word1, loads word2, and the 6th word is accepted SYNC_STAGES+1 edges later.
- Pointer wrap: 10 words through DEPTH=4 with random ack delays of 0-5 cycles.
  - Scoreboard matches in order and count never exceeds 4.
- Protocol error: toggle ack_in while req_out==ack_s.
  - proto_err=1 SYNC_STAGES edges later and stays 1.
  - A following legal transfer still completes correctly.
- Reset mid-operation: assert rst_n=0 with count=3 and req_out pending.
  - Outputs immediately read 0, count=0, proto_err=0.
  - After release, a fresh word 5 transfers normally.

Source files
------------

// File: rtl/handshake_pipe_fifo_pkg.sv
// Shared definitions for the two-phase handshake FIFO stage
// and its sibling pipeline blocks.
package handshake_pipe_fifo_pkg;

    localparam logic PHASE0 = 1'b0;

    localparam int PAYLOAD_W = 3;

    typedef logic [PAYLOAD_W-1:0] payload_t;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/handshake_pipe_fifo_sync.sv
// Single-bit multi-flop synchroniser with asynchronous
// active-low clear to the phase-0 value.
module hs_sync
    import handshake_pipe_fifo_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {STAGES{PHASE0}};
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/handshake_pipe_fifo.sv
// Two-phase in, two-phase out buffering stage with occupancy
// reporting and sticky protocol-violation detection.
module handshake_pipe_fifo
    import handshake_pipe_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 3,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_in,
    output logic                         ack_out,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic                         req_out,
    input  logic                         ack_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         proto_err
);

    localparam int CW = occ_width(DEPTH);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic req_s;
    logic ack_s;
    logic req_s_d;
    logic ack_s_d;
    logic in_pend_d;
    logic out_busy_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic in_pend;
    logic out_busy;
    logic push;
    logic pop;
    logic viol;

    hs_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (req_in),
        .q     (req_s)
    );

    hs_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ack_in),
        .q     (ack_s)
    );

    assign in_pend  = (req_s != ack_out);
    assign out_busy = (req_out != ack_s);
    assign push     = in_pend && (count < FULL_CNT);
    assign pop      = !out_busy && (count != '0);

    // A toggle is judged against the handshake state that held
    // just before the synchronised edge arrived.
    assign viol = ((ack_s != ack_s_d) && !out_busy_d)
               || ((req_s != req_s_d) && in_pend_d);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_out    <= PHASE0;
            req_out    <= PHASE0;
            data_out   <= '0;
            count      <= '0;
            proto_err  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            req_s_d    <= PHASE0;
            ack_s_d    <= PHASE0;
            in_pend_d  <= 1'b0;
            out_busy_d <= 1'b0;
        end else begin
            req_s_d    <= req_s;
            ack_s_d    <= ack_s;
            in_pend_d  <= in_pend;
            out_busy_d <= out_busy;
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                ack_out <= ~ack_out;
            end
            if (pop) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
                req_out  <= ~req_out;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (viol) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_handshake_pipe_fifo.sv
// Directed and randomised bench for handshake_pipe_fifo,
// checked against an in-order word queue model.
module tb_handshake_pipe_fifo;

    localparam int DW    = 3;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          req_in;
    logic          ack_out;
    logic [DW-1:0] data_in;
    logic          req_out;
    logic          ack_in;
    logic [DW-1:0] data_out;
    logic [CW-1:0] count;
    logic          proto_err;

    int checks;
    int failures;

    logic [DW-1:0] send_q[$];
    logic [DW-1:0] exp_q[$];
    int   acks;
    int   reqs;
    int   max_cnt;
    logic seen_ack;
    logic seen_req;
    bit   dn_en;
    int   dly_min;
    int   dly_max;
    bit   pend;
    int   tmr;

    handshake_pipe_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .ack_out   (ack_out),
        .data_in   (data_in),
        .req_out   (req_out),
        .ack_in    (ack_in),
        .data_out  (data_out),
        .count     (count),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: observe toggles, run the downstream acker, then
    // offer the next upstream word once the previous one is acked.
    task automatic tick();
        logic [31:0] want;
        @(posedge clk);
        #1;
        if (ack_out !== seen_ack) begin
            seen_ack = ack_out;
            acks++;
        end
        if (req_out !== seen_req) begin
            seen_req = req_out;
            reqs++;
            want = 32'hDEAD;
            if (exp_q.size() > 0) want = 32'(exp_q.pop_front());
            chk("stream_data", 32'(data_out), want);
            if (dn_en) begin
                pend = 1'b1;
                tmr  = $urandom_range(dly_max, dly_min);
            end
        end
        if (int'(count) > max_cnt) max_cnt = int'(count);
        if (pend && dn_en) begin
            if (tmr == 0) begin
                ack_in = ~ack_in;
                pend   = 1'b0;
            end else begin
                tmr--;
            end
        end
        if (req_in === ack_out && send_q.size() > 0) begin
            data_in = send_q.pop_front();
            exp_q.push_back(data_in);
            req_in = ~req_in;
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req_in  = 1'b0;
        ack_in  = 1'b0;
        data_in = '0;
        send_q.delete();
        exp_q.delete();
        acks = 0; reqs = 0; max_cnt = 0;
        seen_ack = 1'b0; seen_req = 1'b0;
        dn_en = 1'b0; pend = 1'b0; tmr = 0;
        dly_min = 0; dly_max = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_until(input int nreq, input int bound,
                             input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (reqs >= nreq && !pend) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (reqs >= nreq && !pend) done = 1'b1;
        chk(tag, 32'(done), 1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // reset state
        do_reset();
        chk("rst_ack_out", 32'(ack_out), 0);
        chk("rst_req_out", 32'(req_out), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_proto_err", 32'(proto_err), 0);

        // single word latency
        data_in = 3'd1;
        req_in  = 1'b1;
        exp_q.push_back(3'd1);
        tick();
        chk("sw_e0_ack", 32'(ack_out), 0);
        tick();
        chk("sw_e1_ack", 32'(ack_out), 0);
        tick();
        chk("sw_e2_ack", 32'(ack_out), 1);
        chk("sw_e2_count", 32'(count), 1);
        chk("sw_e2_req", 32'(req_out), 0);
        tick();
        chk("sw_e3_req", 32'(req_out), 1);
        chk("sw_e3_data", 32'(data_out), 1);
        chk("sw_e3_count", 32'(count), 0);

        // stream order with 3-cycle acknowledge
        do_reset();
        send_q = '{3'd1, 3'd2, 3'd3, 3'd4};
        dn_en = 1'b1; dly_min = 3; dly_max = 3;
        run_until(4, 300, "st_timeout");
        chk("st_acks", 32'(acks), 4);
        chk("st_reqs", 32'(reqs), 4);
        chk("st_left", 32'(exp_q.size()), 0);
        chk("st_proto", 32'(proto_err), 0);

        // full / backpressure
        do_reset();
        send_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        repeat (40) tick();
        chk("full_acks", 32'(acks), 5);
        chk("full_count", 32'(count), DEPTH);
        chk("full_reqs", 32'(reqs), 1);
        chk("full_data", 32'(data_out), 1);
        chk("full_pending", 32'(req_in ^ ack_out), 1);
        ack_in = ~ack_in;
        tick();
        chk("bp_e0_data", 32'(data_out), 1);
        tick();
        chk("bp_e1_acks", 32'(acks), 5);
        tick();
        chk("bp_e2_reqs", 32'(reqs), 2);
        chk("bp_e2_count", 32'(count), DEPTH - 1);
        chk("bp_e2_acks", 32'(acks), 5);
        tick();
        chk("bp_e3_acks", 32'(acks), 6);
        chk("bp_e3_count", 32'(count), DEPTH);
        pend = 1'b1; tmr = 0;
        dn_en = 1'b1; dly_min = 0; dly_max = 2;
        run_until(6, 400, "bp_drain_timeout");
        chk("bp_left", 32'(exp_q.size()), 0);
        chk("bp_proto", 32'(proto_err), 0);

        // pointer wrap with random acknowledge delay
        do_reset();
        for (int i = 0; i < 10; i++) send_q.push_back(DW'($urandom_range(7, 0)));
        dn_en = 1'b1; dly_min = 0; dly_max = 5;
        run_until(10, 1000, "wrap_timeout");
        chk("wrap_acks", 32'(acks), 10);
        chk("wrap_left", 32'(exp_q.size()), 0);
        chk("wrap_max_cnt", 32'(max_cnt <= DEPTH), 1);
        chk("wrap_proto", 32'(proto_err), 0);

        // acknowledge with no outstanding request
        do_reset();
        ack_in = 1'b1;
        tick();
        chk("pe_e0", 32'(proto_err), 0);
        tick();
        chk("pe_e1", 32'(proto_err), 0);
        tick();
        chk("pe_e2", 32'(proto_err), 1);
        repeat (3) tick();
        chk("pe_sticky", 32'(proto_err), 1);
        ack_in = 1'b0;
        repeat (4) tick();
        send_q = '{3'd5};
        dn_en = 1'b1; dly_min = 1; dly_max = 1;
        run_until(1, 200, "pe_xfer_timeout");
        chk("pe_xfer_left", 32'(exp_q.size()), 0);
        chk("pe_xfer_acks", 32'(acks), 1);
        chk("pe_still", 32'(proto_err), 1);

        // reset in the middle of traffic
        do_reset();
        send_q = '{3'd6, 3'd7, 3'd3, 3'd2};
        repeat (30) tick();
        chk("mr_count", 32'(count), 3);
        chk("mr_req", 32'(req_out), 1);
        rst_n = 1'b0;
        #2;
        chk("mr_ack_out", 32'(ack_out), 0);
        chk("mr_req_out", 32'(req_out), 0);
        chk("mr_data_out", 32'(data_out), 0);
        chk("mr_count0", 32'(count), 0);
        chk("mr_proto", 32'(proto_err), 0);
        do_reset();
        send_q = '{3'd5};
        dn_en = 1'b1; dly_min = 2; dly_max = 2;
        run_until(1, 200, "mr_xfer_timeout");
        chk("mr_xfer_left", 32'(exp_q.size()), 0);
        chk("mr_xfer_acks", 32'(acks), 1);
        chk("mr_xfer_proto", 32'(proto_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
